// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and helpers for the data-memory SRAM bridge.
// Optional DMEM_KSEG_TRANSLATE_EN selects the fixed kseg0/kseg1 address mapping.
package dmem_sram_bridge_pkg;

   localparam int unsigned DMEM_ADDR_W = 32;
   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned STRB_W      = DMEM_DATA_W / 8;
   localparam int unsigned OP_W        = 6;

   // Memory op codes, identical to the execute-stage arbiter encoding
   localparam logic [OP_W-1:0] OP_LB  = 6'h20;
   localparam logic [OP_W-1:0] OP_LH  = 6'h21;
   localparam logic [OP_W-1:0] OP_LW  = 6'h23;
   localparam logic [OP_W-1:0] OP_LBU = 6'h24;
   localparam logic [OP_W-1:0] OP_LHU = 6'h25;
   localparam logic [OP_W-1:0] OP_SB  = 6'h28;
   localparam logic [OP_W-1:0] OP_SH  = 6'h29;
   localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic                   wr;
      logic                   ld;
      logic [OP_W-1:0]        op;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic                   wr;
      logic [1:0]             size;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [STRB_W-1:0]      wstrb;
      logic [DMEM_DATA_W-1:0] wdata;
   } bus_req_t;

   function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
      logic [1:0] sz;
      sz = SIZE_WORD;
      if (op == OP_LB || op == OP_LBU || op == OP_SB) sz = SIZE_BYTE;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) sz = SIZE_HALF;
      return sz;
   endfunction

   function automatic logic [DMEM_ADDR_W-1:0] map_addr(input logic [DMEM_ADDR_W-1:0] a);
      logic [DMEM_ADDR_W-1:0] m;
`ifdef DMEM_KSEG_TRANSLATE_EN
      // kseg0/kseg1 alias the low 512 MB of physical space
      m = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
      m = a;
`endif
      return m;
   endfunction

   // Turn a request into bus fields: size, strobes and lane-replicated store data
   function automatic bus_req_t format_req(input mem_req_t r);
      bus_req_t b;
      b.wr    = r.wr;
      b.size  = op_size(r.op);
      b.addr  = map_addr(r.addr);
      b.wstrb = '0;
      b.wdata = r.wdata;
      case (b.size)
         SIZE_BYTE: begin
            b.wdata = {4{r.wdata[7:0]}};
            if (r.wr) b.wstrb = 4'b0001 << r.addr[1:0];
         end
         SIZE_HALF: begin
            b.wdata = {2{r.wdata[15:0]}};
            if (r.wr) b.wstrb = r.addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            if (r.wr) b.wstrb = 4'hF;
         end
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dmem_sram_bridge_load_align.sv
// Load data extraction: picks byte/half from a raw word and sign/zero-extends it.
module dmem_load_align
   import dmem_sram_bridge_pkg::*;
(
   input  logic [OP_W-1:0]        op,
   input  logic [1:0]             addr_lo,
   input  logic [DMEM_DATA_W-1:0] raw,
   output logic [DMEM_DATA_W-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
      data_c   = raw;
      case (op)
         OP_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data_c = {24'h0, byte_sel};
         OP_LH:   data_c = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data_c = {16'h0, half_sel};
         default: data_c = raw;
      endcase
   end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Responder for the merged data-memory request bus; drives an SRAM-like req/addr_ok/data_ok bus.
// Optional DMEM_KSEG_TRANSLATE_EN applies the fixed kseg0/kseg1 mapping to data_addr.
module dmem_sram_bridge
   import dmem_sram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              E_mem_en,
   input  logic              E_mem_ren,
   input  logic              E_mem_wen,
   input  logic [OP_W-1:0]   E_mem_op,
   input  logic [ADDR_W-1:0] E_mem_addr,
   input  logic [DATA_W-1:0] E_mem_wdata,
   output logic [DATA_W-1:0] M_mem_rdata,
   output logic              mem_stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic [DATA_W-1:0] data_rdata,
   input  logic              data_data_ok
);

   state_e            state_q, state_d;
   mem_req_t          req_q, req_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   mem_req_t          e_req;
   bus_req_t          bus;
   logic [DATA_W-1:0] load_data_c;

   // A request with neither ren nor wen is handled as a load
   always_comb begin
      e_req.wr    = E_mem_wen;
      e_req.ld    = E_mem_ren | ~E_mem_wen;
      e_req.op    = E_mem_op;
      e_req.addr  = E_mem_addr;
      e_req.wdata = E_mem_wdata;
   end

   dmem_load_align u_load_align (
      .op      (req_q.op),
      .addr_lo (req_q.addr[1:0]),
      .raw     (data_rdata),
      .data_c  (load_data_c)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rdata_d   = rdata_q;
      data_req  = 1'b0;
      mem_stall = 1'b0;
      bus       = format_req(req_q);
      unique case (state_q)
         IDLE: begin
            // Bus fields follow the execute stage directly so addr_ok can land this cycle
            bus       = format_req(e_req);
            data_req  = E_mem_en;
            mem_stall = E_mem_en;
            if (E_mem_en) begin
               req_d   = e_req;
               state_d = data_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            data_req  = 1'b1;
            mem_stall = 1'b1;
            if (data_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            mem_stall = ~data_data_ok;
            if (data_data_ok) begin
               state_d = IDLE;
               if (req_q.ld) rdata_d = load_data_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   assign data_wr     = bus.wr;
   assign data_size   = bus.size;
   assign data_addr   = bus.addr;
   assign data_wstrb  = bus.wstrb;
   assign data_wdata  = bus.wdata;
   assign M_mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed, table-driven bench for dmem_sram_bridge with a few hand-written reset sequences.
module tb_dmem_sram_bridge;

   logic        clk;
   logic        resetn;
   logic        E_mem_en, E_mem_ren, E_mem_wen;
   logic [5:0]  E_mem_op;
   logic [31:0] E_mem_addr, E_mem_wdata;
   logic [31:0] M_mem_rdata;
   logic        mem_stall, data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_rdata;

   dmem_sram_bridge dut (
      .clk          (clk),
      .resetn       (resetn),
      .E_mem_en     (E_mem_en),
      .E_mem_ren    (E_mem_ren),
      .E_mem_wen    (E_mem_wen),
      .E_mem_op     (E_mem_op),
      .E_mem_addr   (E_mem_addr),
      .E_mem_wdata  (E_mem_wdata),
      .M_mem_rdata  (M_mem_rdata),
      .mem_stall    (mem_stall),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_rdata   (data_rdata),
      .data_data_ok (data_data_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          a_dly;
      int          d_dly;
      logic [1:0]  e_size;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_upd;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef DMEM_KSEG_TRANSLATE_EN
      if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
      return a;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      E_mem_en     = 1'b0;
      E_mem_ren    = 1'b0;
      E_mem_wen    = 1'b0;
      E_mem_op     = 6'h0;
      E_mem_addr   = 32'h0;
      E_mem_wdata  = 32'h0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
   endtask

   // One complete transaction; E_* are scrambled after the first cycle to prove the latch is used
   task automatic run_txn(input vec_t v);
      int hs;
      hs = 0;
      @(posedge clk); #1;
      E_mem_en     = 1'b1;
      E_mem_ren    = v.ren;
      E_mem_wen    = v.wen;
      E_mem_op     = v.op;
      E_mem_addr   = v.addr;
      E_mem_wdata  = v.wdata;
      data_rdata   = v.rdata;
      data_data_ok = 1'b0;
      data_addr_ok = (v.a_dly == 0);
      for (int k = 0; k <= v.a_dly; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            E_mem_addr   = ~v.addr;
            E_mem_wdata  = ~v.wdata;
            data_addr_ok = (k == v.a_dly);
         end
         @(negedge clk);
         check({v.name, " req"},   32'(data_req),   32'd1);
         check({v.name, " stall"}, 32'(mem_stall),  32'd1);
         check({v.name, " wr"},    32'(data_wr),    32'(v.wen));
         check({v.name, " size"},  32'(data_size),  32'(v.e_size));
         check({v.name, " strb"},  32'(data_wstrb), 32'(v.e_strb));
         check({v.name, " wdata"}, data_wdata,      v.e_wdata);
         check({v.name, " addr"},  data_addr,       exp_addr(v.addr));
         if (data_req && data_addr_ok) hs++;
      end
      for (int k = 0; k <= v.d_dly; k++) begin
         @(posedge clk); #1;
         E_mem_addr   = ~v.addr;
         data_addr_ok = 1'b0;
         data_data_ok = (k == v.d_dly);
         @(negedge clk);
         check({v.name, " wait req"},   32'(data_req),  32'd0);
         check({v.name, " wait stall"}, 32'(mem_stall), 32'(k != v.d_dly));
         if (data_req && data_addr_ok) hs++;
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      if (v.e_upd) exp_rdata = v.e_rdata;
      check({v.name, " rdata"},      M_mem_rdata,     exp_rdata);
      check({v.name, " done stall"}, 32'(mem_stall),  32'd0);
      check({v.name, " handshakes"}, 32'(hs),         32'd1);
   endtask

   initial begin
      vecs[0]  = '{"SW",    6'h2B, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         0, 0, 2'd2, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[1]  = '{"SB",    6'h28, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_00A5, 32'h0,         0, 0, 2'd0, 4'h8, 32'hA5A5_A5A5, 1'b0, 32'h0};
      vecs[2]  = '{"LB",    6'h20, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         32'h1234_80FF, 0, 0, 2'd0, 4'h0, 32'h0,         1'b1, 32'hFFFF_FF80};
      vecs[3]  = '{"LBU",   6'h24, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         32'h1234_80FF, 0, 0, 2'd0, 4'h0, 32'h0,         1'b1, 32'h0000_0080};
      vecs[4]  = '{"LH",    6'h21, 1'b1, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_0000, 0, 0, 2'd1, 4'h0, 32'h0,         1'b1, 32'hFFFF_8001};
      vecs[5]  = '{"LHU",   6'h25, 1'b1, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_0000, 0, 0, 2'd1, 4'h0, 32'h0,         1'b1, 32'h0000_8001};
      vecs[6]  = '{"LWslow",6'h23, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 3, 4, 2'd2, 4'h0, 32'h0,         1'b1, 32'hCAFE_F00D};
      vecs[7]  = '{"SHhi",  6'h29, 1'b0, 1'b1, 32'h0000_0006, 32'h1234_BEEF, 32'h5555_5555, 1, 2, 2'd1, 4'hC, 32'hBEEF_BEEF, 1'b0, 32'h0};
      vecs[8]  = '{"NOREN", 6'h23, 1'b0, 1'b0, 32'hBFC0_0010, 32'h0,         32'h1122_3344, 0, 1, 2'd2, 4'h0, 32'h0,         1'b1, 32'h1122_3344};
      vecs[9]  = '{"LB0",   6'h20, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_007F, 2, 0, 2'd0, 4'h0, 32'h0,         1'b1, 32'h0000_007F};
      vecs[10] = '{"SHlo",  6'h29, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_5A5A, 32'h0,         0, 0, 2'd1, 4'h3, 32'h5A5A_5A5A, 1'b0, 32'h0};
      vecs[11] = '{"LH0",   6'h21, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_7FFF, 0, 0, 2'd1, 4'h0, 32'h0,         1'b1, 32'h0000_7FFF};

      idle_inputs();
      data_rdata = 32'h0;
      exp_rdata  = 32'h0;
      resetn     = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("reset rdata", M_mem_rdata,     32'h0);
      check("reset req",   32'(data_req),   32'd0);
      check("reset stall", 32'(mem_stall),  32'd0);

      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // Reset while waiting for data_ok, then a stray data_ok in IDLE
      @(posedge clk); #1;
      E_mem_en     = 1'b1;
      E_mem_ren    = 1'b1;
      E_mem_op     = 6'h23;
      E_mem_addr   = 32'h0000_0040;
      data_rdata   = 32'hFEED_FACE;
      data_addr_ok = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("rst wait stall", 32'(mem_stall), 32'd1);
      #1 resetn = 1'b0;
      #1;
      exp_rdata = 32'h0;
      check("rst rdata",  M_mem_rdata,    exp_rdata);
      check("rst stall",  32'(mem_stall), 32'd0);
      check("rst req",    32'(data_req),  32'd0);
      @(posedge clk); #1;
      resetn       = 1'b1;
      data_data_ok = 1'b1;
      @(negedge clk);
      check("stray stall", 32'(mem_stall), 32'd0);
      check("stray req",   32'(data_req),  32'd0);
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      @(negedge clk);
      check("stray rdata", M_mem_rdata, exp_rdata);

      run_txn(vecs[2]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
